rr_bus_arbiter: RTL



---
 rtl/rr_bus_arbiter_pkg.sv | 26 ++
 rtl/rr_bus_arbiter_if.sv | 53 +++++
 rtl/rr_priority_picker.sv | 47 ++++
 rtl/rr_bus_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/rr_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the SoC bus arbiter and related bus blocks:
//   - arb_state_e : arbiter FSM states (ARB_IDLE, ARB_BUSY)
//   - BUS_AW / BUS_DW / BUS_WEW : address, data and byte-enable widths
//   - TMO_W       : width of the bus watchdog counter
//   - ptr_width() : width of a round-robin pointer for n requesters (min 1)
// -----------------------------------------------------------------------------
package bus_pkg;

  localparam int BUS_AW  = 32;
  localparam int BUS_DW  = 32;
  localparam int BUS_WEW = 4;
  localparam int TMO_W   = 16;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // A single requester still needs a 1-bit pointer so every port has width.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_bus_arbiter_if
// Bundles the per-master request side and the single slave side of the shared
// SoC bus. Master i occupies slice [W*i +: W] of every packed per-master vector.
//   modport slave  : the arbiter's view (serves the masters, drives the slave)
//   modport master : the environment's view (masters + mux_switch side)
// Signals:
//   master_address/master_data_i/master_wr/master_enable : per-master requests
//   master_data_o/master_ready/master_error              : responses to masters
//   slave_address/slave_data_o/slave_wr/slave_enable     : granted request
//   slave_data_i/slave_ready/slave_error                 : slave response
//   grant                                                : registered one-hot
// -----------------------------------------------------------------------------
interface rr_bus_arbiter_if #(
  parameter int NMASTERS = 3
);
  import bus_pkg::*;

  logic [BUS_AW*NMASTERS-1:0]  master_address;
  logic [BUS_DW*NMASTERS-1:0]  master_data_i;
  logic [BUS_WEW*NMASTERS-1:0] master_wr;
  logic [NMASTERS-1:0]         master_enable;
  logic [BUS_DW-1:0]           master_data_o;
  logic [NMASTERS-1:0]         master_ready;
  logic [NMASTERS-1:0]         master_error;

  logic [BUS_DW-1:0]           slave_data_i;
  logic                        slave_ready;
  logic                        slave_error;
  logic [BUS_AW-1:0]           slave_address;
  logic [BUS_DW-1:0]           slave_data_o;
  logic [BUS_WEW-1:0]          slave_wr;
  logic                        slave_enable;

  logic [NMASTERS-1:0]         grant;

  modport slave (
    input  master_address, master_data_i, master_wr, master_enable,
    output master_data_o, master_ready, master_error,
    input  slave_data_i, slave_ready, slave_error,
    output slave_address, slave_data_o, slave_wr, slave_enable,
    output grant
  );

  modport master (
    output master_address, master_data_i, master_wr, master_enable,
    input  master_data_o, master_ready, master_error,
    output slave_data_i, slave_ready, slave_error,
    input  slave_address, slave_data_o, slave_wr, slave_enable,
    input  grant
  );

endinterface

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin selector: returns the first set request found
// searching upward from i_ptr with wrap (ptr, ptr+1 .. N-1, 0 .. ptr-1).
// Ports:
//   i_req   [N-1:0]  request vector
//   i_ptr   [PW-1:0] highest-priority index for this pick
//   o_grant [N-1:0]  one-hot winner, all-zero when no request
// -----------------------------------------------------------------------------
module rr_priority_picker
  import bus_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);

  logic [N-1:0] w_rot;
  logic         w_found;
  int           w_ofs;
  int           w_idx;

  // Rotating a doubled copy right by ptr puts request[ptr] at bit 0, so a
  // plain lowest-bit search on the low half is the wrapped search.
  assign w_rot = N'({i_req, i_req} >> i_ptr);

  // NOTE: every variable written in an always_comb gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_found = 1'b0;
    w_ofs   = 0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_ofs   = k;
      end
    end
    w_idx = (int'(i_ptr) + w_ofs) % N;
    for (int j = 0; j < N; j++) begin
      o_grant[j] = w_found && (j == w_idx);
    end
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// -----------------------------------------------------------------------------
// rr_bus_arbiter
// Round-robin arbiter sharing the SoC bus between NMASTERS masters, placed in
// front of mux_switch. IDLE picks the next requester from ptr; BUSY forwards
// the granted master's request and routes the slave's ready/error back to it.
// Completion, abort (enable dropped) or timeout return to IDLE and advance ptr
// past the served master.
// Optional feature: define RR_BUS_ARBITER_TIMEOUT_EN to enable a watchdog that
// forces master_error after TIMEOUT_CYCLES unanswered BUSY cycles.
// Ports:
//   clk  bus clock
//   rst  synchronous active-high reset
//   bus  rr_bus_arbiter_if.slave (master request side + slave side + grant)
// -----------------------------------------------------------------------------
module rr_bus_arbiter
  import bus_pkg::*;
#(
  parameter int NMASTERS       = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  rr_bus_arbiter_if.slave     bus
);

  localparam int PW = ptr_width(NMASTERS);

  arb_state_e          r_state, w_state_nxt;
  logic [NMASTERS-1:0] r_grant, w_grant_nxt, w_pick;
  logic [PW-1:0]       r_ptr, w_ptr_nxt, w_ptr_adv;

  logic [BUS_AW-1:0]   w_addr;
  logic [BUS_DW-1:0]   w_data;
  logic [BUS_WEW-1:0]  w_wr;
  logic                w_sel_en;
  logic                w_busy;
  logic                w_resp;
  logic                w_timeout;
  logic                w_end;

  rr_priority_picker #(
    .N  (NMASTERS),
    .PW (PW)
  ) u_picker (
    .i_req   (bus.master_enable),
    .i_ptr   (r_ptr),
    .o_grant (w_pick)
  );

  // Grant-driven mux; r_grant is zero in IDLE so everything muxes to zero.
  always_comb begin
    w_addr    = '0;
    w_data    = '0;
    w_wr      = '0;
    w_sel_en  = 1'b0;
    w_ptr_adv = '0;
    for (int j = 0; j < NMASTERS; j++) begin
      if (r_grant[j]) begin
        w_addr    = bus.master_address[BUS_AW*j +: BUS_AW];
        w_data    = bus.master_data_i[BUS_DW*j +: BUS_DW];
        w_wr      = bus.master_wr[BUS_WEW*j +: BUS_WEW];
        w_sel_en  = bus.master_enable[j];
        w_ptr_adv = PW'((j + 1) % NMASTERS);
      end
    end
  end

  assign w_busy = (r_state == ARB_BUSY);
  assign w_resp = bus.slave_ready | bus.slave_error;

`ifdef RR_BUS_ARBITER_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] r_cnt;

  // Held at zero in IDLE, so the first BUSY cycle sees 0 and cycle k sees k-1.
  always_ff @(posedge clk) begin
    if (rst || !w_busy) r_cnt <= '0;
    else                r_cnt <= r_cnt + 1'b1;
  end

  // A response in the same cycle as the limit wins over the watchdog.
  assign w_timeout = w_busy && w_sel_en && !w_resp && (r_cnt == TMO_LIMIT);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TMO_W'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
`endif

  // Dropped enable is an abort: it ends BUSY and suppresses any pulse.
  assign w_end = w_busy && (!w_sel_en || w_resp || w_timeout);

  assign bus.master_data_o = bus.slave_data_i;
  assign bus.slave_address = w_addr;
  assign bus.slave_data_o  = w_data;
  assign bus.slave_wr      = w_wr;
  assign bus.slave_enable  = w_busy && w_sel_en && !w_timeout;
  assign bus.grant         = r_grant;
  // Error has priority over ready when both arrive together.
  assign bus.master_ready  = r_grant & {NMASTERS{w_busy && w_sel_en &&
                                                  bus.slave_ready && !bus.slave_error}};
  assign bus.master_error  = r_grant & {NMASTERS{w_busy && w_sel_en &&
                                                  (bus.slave_error || w_timeout)}};

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ARB_IDLE: begin
        if (|bus.master_enable) begin
          w_state_nxt = ARB_BUSY;
          w_grant_nxt = w_pick;
        end
      end
      ARB_BUSY: begin
        if (w_end) begin
          w_state_nxt = ARB_IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = w_ptr_adv;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

endmodule
